// File: rtl/othello_board_datapath.sv
// -----------------------------------------------------------------------------
// othello_board_datapath
//
// Holds the 8x8 Othello board and the cursor, and renders the cursor cell as
// a pixel stream for the VGA adapter on command from the game-control FSM.
//
// Parameters
//   CELL_PX : cell edge in pixels (power of two, 4..16)
//   ORG_X   : board left pixel column
//   ORG_Y   : board top pixel row
//
// Ports
//   clk, reset_n                        clock, asynchronous active-low reset
//   draw_cell / plot_empty / place_disk command strobes (level-sampled)
//   turn_side                           0 = black to move, 1 = white to move
//   ld_key + move_*                     one cursor step, saturating at 0 / 7
//   x, y, colour, plot                  pixel stream to the VGA adapter
//   busy                                render in progress
//   done                                one-cycle end-of-command pulse
//   place_err                           one-cycle pulse: place on occupied cell
//   win                                 board full (held until reset)
//   cur_x, cur_y                        cursor cell coordinates
// -----------------------------------------------------------------------------
module othello_board_datapath #(
  parameter int CELL_PX = 8,
  parameter int ORG_X   = 48,
  parameter int ORG_Y   = 28
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       draw_cell,
  input  logic       plot_empty,
  input  logic       place_disk,
  input  logic       turn_side,
  input  logic       ld_key,
  input  logic       move_up,
  input  logic       move_down,
  input  logic       move_left,
  input  logic       move_right,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done,
  output logic       place_err,
  output logic       win,
  output logic [2:0] cur_x,
  output logic [2:0] cur_y
);

  localparam int PXW  = $clog2(CELL_PX);
  localparam int IDXW = 2 * PXW;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(CELL_PX * CELL_PX - 1);
  localparam logic [PXW-1:0]  EDGE_PX  = PXW'(CELL_PX - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RENDER = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  // Cell encoding: 0 = empty, 1 = black, 2 = white.
  logic [1:0]      board_reg [64];
  logic [6:0]      count_reg;
  logic [1:0]      state_reg;
  logic [2:0]      cur_x_reg, cur_y_reg;
  logic [IDXW-1:0] pix_idx_reg;
  logic            highlight_reg;
  logic [1:0]      cell_reg;
  logic [7:0]      x_reg;
  logic [6:0]      y_reg;
  logic [2:0]      colour_reg;
  logic            plot_reg, busy_reg, done_reg, place_err_reg, win_reg;

  logic [2:0]      cur_x_next, cur_y_next;
  logic [6:0]      count_next;
  logic            accept;
  logic [5:0]      cell_addr;
  logic [1:0]      cell_val, cell_val_new;
  logic            place_ok, place_bad, start_render, start_hl;
  logic [IDXW-1:0] render_idx;
  logic [PXW-1:0]  px_sel, py_sel;
  logic            hl_sel;
  logic [1:0]      occ_sel;

  // Opening position: white on (3,3),(4,4), black on (3,4),(4,3); index = y*8+x.
  function automatic logic [1:0] init_cell(input int idx);
    logic [1:0] v;
    v = 2'd0;
    if (idx == 27 || idx == 36) v = 2'd2;
    if (idx == 28 || idx == 35) v = 2'd1;
    return v;
  endfunction

  function automatic logic [7:0] pix_x(input logic [2:0] cx, input logic [PXW-1:0] px);
    return 8'(ORG_X) + 8'(cx) * 8'(CELL_PX) + 8'(px);
  endfunction

  function automatic logic [6:0] pix_y(input logic [2:0] cy, input logic [PXW-1:0] py);
    logic [7:0] full;
    full = 8'(ORG_Y) + 8'(cy) * 8'(CELL_PX) + 8'(py);
    return full[6:0];
  endfunction

  function automatic logic [2:0] pix_colour(input logic [PXW-1:0] px, input logic [PXW-1:0] py,
                                            input logic hl, input logic [1:0] occ);
    logic [2:0] c;
    if (px == '0 || px == EDGE_PX || py == '0 || py == EDGE_PX) begin
      c = hl ? 3'b100 : 3'b001;
    end else begin
      case (occ)
        2'd1:    c = 3'b000;
        2'd2:    c = 3'b111;
        default: c = 3'b010;
      endcase
    end
    return c;
  endfunction

  // Commands and cursor steps are only taken outside RENDER.
  assign accept = (state_reg != S_RENDER);

  always_comb begin
    cur_x_next = cur_x_reg;
    cur_y_next = cur_y_reg;
    if (accept && ld_key) begin
      if (move_up)
        cur_y_next = (cur_y_reg == 3'd0) ? 3'd0 : cur_y_reg - 3'd1;
      else if (move_down)
        cur_y_next = (cur_y_reg == 3'd7) ? 3'd7 : cur_y_reg + 3'd1;
      else if (move_left)
        cur_x_next = (cur_x_reg == 3'd0) ? 3'd0 : cur_x_reg - 3'd1;
      else if (move_right)
        cur_x_next = (cur_x_reg == 3'd7) ? 3'd7 : cur_x_reg + 3'd1;
    end
  end

  // A command issued together with ld_key acts on the post-step cursor.
  assign cell_addr    = {cur_y_next, cur_x_next};
  assign cell_val     = board_reg[cell_addr];
  assign place_ok     = accept && place_disk && (cell_val == 2'd0);
  assign place_bad    = accept && place_disk && (cell_val != 2'd0);
  assign start_render = accept && (place_ok || (!place_disk && (plot_empty || draw_cell)));
  assign start_hl     = !place_disk && !plot_empty && draw_cell;
  assign cell_val_new = place_ok ? (2'd1 + {1'b0, turn_side}) : cell_val;
  assign count_next   = place_ok ? count_reg + 7'd1 : count_reg;

  // Pixel to present next: pixel 0 on accept, otherwise the following pixel.
  // The placed disk is already visible in the first render of that cell.
  assign render_idx = (state_reg == S_RENDER) ? pix_idx_reg + IDXW'(1) : '0;
  assign px_sel     = render_idx[PXW-1:0];
  assign py_sel     = render_idx[IDXW-1:PXW];
  assign hl_sel     = (state_reg == S_RENDER) ? highlight_reg : start_hl;
  assign occ_sel    = (state_reg == S_RENDER) ? cell_reg : cell_val_new;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) board_reg[i] <= init_cell(i);
    end else if (place_ok) begin
      board_reg[cell_addr] <= cell_val_new;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      count_reg     <= 7'd4;
      cur_x_reg     <= 3'd0;
      cur_y_reg     <= 3'd0;
      pix_idx_reg   <= '0;
      highlight_reg <= 1'b0;
      cell_reg      <= 2'd0;
      x_reg         <= 8'd0;
      y_reg         <= 7'd0;
      colour_reg    <= 3'd0;
      plot_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      place_err_reg <= 1'b0;
      win_reg       <= 1'b0;
    end else begin
      cur_x_reg     <= cur_x_next;
      cur_y_reg     <= cur_y_next;
      count_reg     <= count_next;
      // Looks at the next count so win rises the cycle after the 64th placement.
      win_reg       <= win_reg | (count_next == 7'd64);
      done_reg      <= 1'b0;
      place_err_reg <= 1'b0;
      case (state_reg)
        S_RENDER: begin
          if (pix_idx_reg == LAST_IDX) begin
            state_reg <= S_DONE;
            plot_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            pix_idx_reg <= render_idx;
            x_reg       <= pix_x(cur_x_next, px_sel);
            y_reg       <= pix_y(cur_y_next, py_sel);
            colour_reg  <= pix_colour(px_sel, py_sel, hl_sel, occ_sel);
          end
        end
        default: begin
          if (start_render) begin
            state_reg     <= S_RENDER;
            pix_idx_reg   <= '0;
            highlight_reg <= start_hl;
            cell_reg      <= cell_val_new;
            plot_reg      <= 1'b1;
            busy_reg      <= 1'b1;
            x_reg         <= pix_x(cur_x_next, px_sel);
            y_reg         <= pix_y(cur_y_next, py_sel);
            colour_reg    <= pix_colour(px_sel, py_sel, hl_sel, occ_sel);
          end else if (place_bad) begin
            state_reg     <= S_DONE;
            done_reg      <= 1'b1;
            place_err_reg <= 1'b1;
          end else begin
            state_reg <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign x         = x_reg;
  assign y         = y_reg;
  assign colour    = colour_reg;
  assign plot      = plot_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign place_err = place_err_reg;
  assign win       = win_reg;
  assign cur_x     = cur_x_reg;
  assign cur_y     = cur_y_reg;

endmodule

// File: tb/tb_othello_board_datapath.sv
// -----------------------------------------------------------------------------
// tb_othello_board_datapath
//
// Directed steps plus a randomized phase against a board/cursor model kept as
// plain 2-D arrays; expected pixels come from nested row/column loops.
// -----------------------------------------------------------------------------
module tb_othello_board_datapath;

  localparam int CP = 8;
  localparam int OX = 48;
  localparam int OY = 28;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       draw_cell, plot_empty, place_disk, turn_side, ld_key;
  logic       move_up, move_down, move_left, move_right;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done, place_err, win;
  logic [2:0] cur_x, cur_y;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: bd[x][y] occupant (0 empty, 1 black, 2 white).
  int bd [8][8];
  int mcx, mcy, mcount;

  othello_board_datapath #(.CELL_PX(CP), .ORG_X(OX), .ORG_Y(OY)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .draw_cell  (draw_cell),
    .plot_empty (plot_empty),
    .place_disk (place_disk),
    .turn_side  (turn_side),
    .ld_key     (ld_key),
    .move_up    (move_up),
    .move_down  (move_down),
    .move_left  (move_left),
    .move_right (move_right),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy),
    .done       (done),
    .place_err  (place_err),
    .win        (win),
    .cur_x      (cur_x),
    .cur_y      (cur_y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) bd[i][j] = 0;
    bd[3][3] = 2; bd[4][4] = 2; bd[3][4] = 1; bd[4][3] = 1;
    mcx = 0; mcy = 0; mcount = 4;
  endtask

  function automatic int exp_colour(int px, int py, int hl, int occ);
    if (px == 0 || py == 0 || px == CP - 1 || py == CP - 1) return hl ? 4 : 1;
    if (occ == 1) return 0;
    if (occ == 2) return 7;
    return 2;
  endfunction

  task automatic clear_inputs();
    draw_cell = 0; plot_empty = 0; place_disk = 0; ld_key = 0;
    move_up = 0; move_down = 0; move_left = 0; move_right = 0;
  endtask

  // One transaction: drive for one cycle, update the model, check the outcome.
  // Returns in the DONE cycle of a render/error, so the next call may be
  // accepted there. mv = {up, down, left, right}.
  task automatic do_cmd(input logic pd, input logic pe, input logic dc, input logic lk,
                        input logic [3:0] mv, input logic side);
    int kind; // 0 none, 1 normal render, 2 highlight render, 3 place error
    int occ;
    if (lk) begin
      if (mv[3])      mcy = (mcy > 0) ? mcy - 1 : 0;
      else if (mv[2]) mcy = (mcy < 7) ? mcy + 1 : 7;
      else if (mv[1]) mcx = (mcx > 0) ? mcx - 1 : 0;
      else if (mv[0]) mcx = (mcx < 7) ? mcx + 1 : 7;
    end
    if (pd) begin
      if (bd[mcx][mcy] != 0) kind = 3;
      else begin
        bd[mcx][mcy] = 1 + int'(side);
        mcount++;
        kind = 1;
      end
    end else if (pe) kind = 1;
    else if (dc)     kind = 2;
    else             kind = 0;

    place_disk = pd; plot_empty = pe; draw_cell = dc; ld_key = lk;
    move_up = mv[3]; move_down = mv[2]; move_left = mv[1]; move_right = mv[0];
    turn_side = side;
    @(posedge clk); #1;
    clear_inputs();

    chk("cur_x", 32'(cur_x), 32'(mcx));
    chk("cur_y", 32'(cur_y), 32'(mcy));
    chk("win", 32'(win), 32'(mcount == 64));

    if (kind == 1 || kind == 2) begin
      occ = bd[mcx][mcy];
      for (int i = 0; i < CP * CP; i++) begin
        int px, py;
        px = i % CP; py = i / CP;
        chk("plot", 32'(plot), 32'd1);
        chk("busy", 32'(busy), 32'd1);
        chk("pix_x", 32'(x), 32'(OX + mcx * CP + px));
        chk("pix_y", 32'(y), 32'((OY + mcy * CP + py) % 128));
        chk("colour", 32'(colour), 32'(exp_colour(px, py, kind == 2, occ)));
        @(posedge clk); #1;
      end
      chk("done_render", 32'(done), 32'd1);
      chk("plot_end", 32'(plot), 32'd0);
      chk("busy_end", 32'(busy), 32'd0);
      chk("no_err", 32'(place_err), 32'd0);
      chk("x_hold", 32'(x), 32'(OX + mcx * CP + CP - 1));
    end else if (kind == 3) begin
      chk("place_err", 32'(place_err), 32'd1);
      chk("done_err", 32'(done), 32'd1);
      chk("plot_err", 32'(plot), 32'd0);
      chk("busy_err", 32'(busy), 32'd0);
    end else begin
      chk("done_idle", 32'(done), 32'd0);
      chk("plot_idle", 32'(plot), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
    end
    $display("[TB] txn pd=%0b pe=%0b dc=%0b lk=%0b mv=%b side=%0b kind=%0d cur=(%0d,%0d) count=%0d",
             pd, pe, dc, lk, mv, side, kind, mcx, mcy, mcount);
  endtask

  task automatic goto_cell(input int tx, input int ty);
    logic [3:0] mv;
    for (int k = 0; k < 16 && (mcx != tx || mcy != ty); k++) begin
      if (mcy > ty)      mv = 4'b1000;
      else if (mcy < ty) mv = 4'b0100;
      else if (mcx > tx) mv = 4'b0010;
      else               mv = 4'b0001;
      do_cmd(1'b0, 1'b0, 1'b0, 1'b1, mv, turn_side);
    end
  endtask

  initial begin
    logic side_v;
    reset_n = 1'b0;
    turn_side = 1'b0;
    clear_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_colour", 32'(colour), 32'd0);
    chk("rst_plot", 32'(plot), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(place_err), 32'd0);
    chk("rst_win", 32'(win), 32'd0);
    chk("rst_cur", 32'({cur_x, cur_y}), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Highlighted render of (0,0): 64 pixels, done on the 65th cycle.
    do_cmd(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);

    // Saturation on the left, then seven steps right reach 7, an eighth stays.
    do_cmd(1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b0);
    for (int i = 0; i < 8; i++) do_cmd(1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0);
    chk("cur_x_sat7", 32'(cur_x), 32'd7);

    // Occupied (3,3): error pulse only, which must last a single cycle.
    goto_cell(3, 3);
    do_cmd(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    do_cmd(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    chk("err_single", 32'(place_err), 32'd0);

    // Step left and place black in the same accept cycle.
    do_cmd(1'b1, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b0);

    // Three commands plus move_down from (0,0): plot_empty wins, at (0,1).
    goto_cell(0, 0);
    do_cmd(1'b0, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b0);

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      logic [3:0] mv;
      mv = 4'($urandom_range(0, 15));
      do_cmd(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mv,
             1'($urandom_range(0, 1)));
    end

    // Fill every remaining empty cell, alternating sides; win follows the last.
    side_v = 1'b0;
    for (int cy = 0; cy < 8; cy++) begin
      for (int cx = 0; cx < 8; cx++) begin
        if (bd[cx][cy] == 0) begin
          goto_cell(cx, cy);
          do_cmd(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, side_v);
          side_v = ~side_v;
        end
      end
    end
    chk("win_full", 32'(win), 32'd1);

    // Reset in the middle of a render at pixel 20.
    draw_cell = 1'b1;
    @(posedge clk); #1;
    draw_cell = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    chk("pre_rst_plot", 32'(plot), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_plot", 32'(plot), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("post_rst_plot", 32'(plot), 32'd0);
    end
    chk("post_rst_cur", 32'({cur_x, cur_y}), 32'd0);
    chk("post_rst_win", 32'(win), 32'd0);
    // Board restored: (0,0) empty again, (3,3) white.
    do_cmd(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    goto_cell(3, 3);
    do_cmd(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
